// File: rtl/dsi_pkg.sv
// dsi_pkg: shared definitions for the DSI packet assembler.
//   - dsi_state_t : assembler FSM state encoding
//   - DT_*        : common DSI data-type codes
//   - CRC_POLY / CRC_SEED : long-packet checksum constants (reflected CRC-16)
//   - dsi_ecc()   : 6-bit Hamming ECC over the 24-bit packet header
`timescale 1ns/1ps
package dsi_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_DI      = 4'd1,
    ST_WC0     = 4'd2,
    ST_WC1     = 4'd3,
    ST_ECC     = 4'd4,
    ST_PAYLOAD = 4'd5,
    ST_CRC0    = 4'd6,
    ST_CRC1    = 4'd7,
    ST_DUMMY   = 4'd8
  } dsi_state_t;

  // Common DSI data types
  localparam logic [5:0] DT_VSYNC_START       = 6'h01;
  localparam logic [5:0] DT_GEN_SHORT_WRITE0  = 6'h03;
  localparam logic [5:0] DT_DCS_SHORT_WRITE0  = 6'h05;
  localparam logic [5:0] DT_NULL_PACKET       = 6'h09;
  localparam logic [5:0] DT_BLANKING_PACKET   = 6'h19;
  localparam logic [5:0] DT_GEN_LONG_WRITE    = 6'h29;
  localparam logic [5:0] DT_DCS_LONG_WRITE    = 6'h39;

  // Reflected form of x^16+x^12+x^5+1
  localparam logic [15:0] CRC_POLY = 16'h8408;
  localparam logic [15:0] CRC_SEED = 16'hFFFF;

  // DSI header ECC: parity bits P0..P5 over D[23:0] = {WC MSB, WC LSB, DI}
  function automatic logic [5:0] dsi_ecc(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
    p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
    p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
    p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
    return p;
  endfunction

endpackage

// File: rtl/dsi_crc16.sv
// dsi_crc16: combinational one-byte step of the reflected CRC-16
// (poly 0x8408), data consumed LSB first.
//   crc_in  : current CRC register
//   data    : byte being absorbed
//   crc_out : CRC after absorbing data
`timescale 1ns/1ps
module dsi_crc16
  import dsi_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  logic [15:0] c;

  always_comb begin
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ CRC_POLY;
      else                c = c >> 1;
    end
    crc_out = c;
  end

endmodule

// File: rtl/dsi_packet_assembler.sv
// dsi_packet_assembler: builds DSI short/long/dummy packets and streams them
// byte by byte into a lane serializer.
//   clk_base, reset_n          : clock, synchronous active-low reset
//   pkt_valid/pkt_ready        : packet request handshake (fields below)
//   pkt_long, pkt_dummy        : packet kind (dummy overrides long)
//   pkt_vc, pkt_dt, pkt_wc     : virtual channel, data type, word count / short data
//   pld_data/pld_valid/pld_ready : payload byte stream for long packets
//   lane_*                     : lane interface; lane_request pulls one byte
//   busy, underflow            : status; underflow pulses on payload starvation
//   dbg_state                  : current FSM state (dsi_state_t encoding)
//
// Handshakes: a transfer happens in any cycle where both valid and ready are
// high; valid is not required to wait for ready. On the lane side,
// lane_request acts as ready and lane_write as valid, and lane_write is only
// raised in a cycle where lane_request is high.
`timescale 1ns/1ps
module dsi_packet_assembler
  import dsi_pkg::*;
#(
  parameter bit CRC_EN  = 1'b1,
  parameter bit HS_MODE = 1'b1
) (
  input  logic        clk_base,
  input  logic        reset_n,
  input  logic        pkt_valid,
  output logic        pkt_ready,
  input  logic        pkt_long,
  input  logic [1:0]  pkt_vc,
  input  logic [5:0]  pkt_dt,
  input  logic [15:0] pkt_wc,
  input  logic        pkt_dummy,
  input  logic [7:0]  pld_data,
  input  logic        pld_valid,
  output logic        pld_ready,
  output logic [7:0]  lane_data,
  output logic        lane_write,
  output logic        lane_eof,
  output logic        lane_hs,
  output logic        lane_dummy,
  input  logic        lane_request,
  output logic        busy,
  output logic        underflow,
  output logic [3:0]  dbg_state
);

  dsi_state_t  state;
  logic        long_q;
  logic [1:0]  vc_q;
  logic [5:0]  dt_q;
  logic [15:0] wc_q;
  logic [15:0] cnt_q;   // payload bytes still to send
  logic [15:0] crc_q;
  logic [15:0] crc_next;
  logic [15:0] crc_tx;
  logic [5:0]  ecc;
  logic        pld_xfer;

  dsi_crc16 u_crc (
    .crc_in  (crc_q),
    .data    (pld_data),
    .crc_out (crc_next)
  );

  assign ecc      = dsi_ecc({wc_q, vc_q, dt_q});
  assign crc_tx   = CRC_EN ? crc_q : 16'h0000;
  assign pld_xfer = (state == ST_PAYLOAD) && lane_request && pld_valid;

  assign pkt_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign lane_hs   = HS_MODE;
  assign dbg_state = state;

  always_ff @(posedge clk_base) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      long_q <= 1'b0;
      vc_q   <= 2'd0;
      dt_q   <= 6'd0;
      wc_q   <= 16'd0;
      cnt_q  <= 16'd0;
      crc_q  <= CRC_SEED;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pkt_valid) begin
            long_q <= pkt_long;
            vc_q   <= pkt_vc;
            dt_q   <= pkt_dt;
            wc_q   <= pkt_wc;
            cnt_q  <= pkt_wc;
            crc_q  <= CRC_SEED;
            state  <= pkt_dummy ? ST_DUMMY : ST_DI;
          end
        end
        ST_DI:  if (lane_request) state <= ST_WC0;
        ST_WC0: if (lane_request) state <= ST_WC1;
        ST_WC1: if (lane_request) state <= ST_ECC;
        ST_ECC: begin
          if (lane_request) begin
            if (!long_q)             state <= ST_IDLE;
            else if (wc_q == 16'd0)  state <= ST_CRC0;
            else                     state <= ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (pld_xfer) begin
            crc_q <= crc_next;
            cnt_q <= cnt_q - 16'd1;
            if (cnt_q == 16'd1) state <= ST_CRC0;
          end
        end
        ST_CRC0:  if (lane_request) state <= ST_CRC1;
        ST_CRC1:  if (lane_request) state <= ST_IDLE;
        ST_DUMMY: if (lane_request) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Lane byte mux. Flags are qualified by lane_write so they never appear on
  // a cycle that does not carry a byte.
  always_comb begin
    lane_data  = 8'h00;
    lane_write = 1'b0;
    lane_eof   = 1'b0;
    lane_dummy = 1'b0;
    pld_ready  = 1'b0;
    underflow  = 1'b0;
    case (state)
      ST_DI: begin
        lane_data  = {vc_q, dt_q};
        lane_write = lane_request;
      end
      ST_WC0: begin
        lane_data  = wc_q[7:0];
        lane_write = lane_request;
      end
      ST_WC1: begin
        lane_data  = wc_q[15:8];
        lane_write = lane_request;
      end
      ST_ECC: begin
        lane_data  = {2'b00, ecc};
        lane_write = lane_request;
        lane_eof   = lane_request && !long_q;
      end
      ST_PAYLOAD: begin
        lane_data  = pld_data;
        pld_ready  = lane_request;
        lane_write = lane_request && pld_valid;
        underflow  = lane_request && !pld_valid;
      end
      ST_CRC0: begin
        lane_data  = crc_tx[7:0];
        lane_write = lane_request;
      end
      ST_CRC1: begin
        lane_data  = crc_tx[15:8];
        lane_write = lane_request;
        lane_eof   = lane_request;
      end
      ST_DUMMY: begin
        lane_data  = 8'h00;
        lane_write = lane_request;
        lane_eof   = lane_request;
        lane_dummy = lane_request;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dsi_packet_assembler.sv
// tb_dsi_packet_assembler: directed table of packets plus hand-written
// sequences for starvation, busy-time requests and reset mid-packet.
`timescale 1ns/1ps
module tb_dsi_packet_assembler;
  import dsi_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk_base = 1'b0;
  logic reset_n  = 1'b0;
  always #5 clk_base = ~clk_base;

  logic        pkt_valid = 1'b0, pkt_long = 1'b0, pkt_dummy = 1'b0;
  logic [1:0]  pkt_vc = '0;
  logic [5:0]  pkt_dt = '0;
  logic [15:0] pkt_wc = '0;
  logic [7:0]  pld_data = '0;
  logic        pld_valid = 1'b0, lane_request = 1'b0;
  logic        pkt_ready, pld_ready, lane_write, lane_eof, lane_hs, lane_dummy;
  logic        busy, underflow;
  logic [7:0]  lane_data;
  logic [3:0]  dbg_state;

  dsi_packet_assembler dut (
    .clk_base(clk_base), .reset_n(reset_n),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_long(pkt_long),
    .pkt_vc(pkt_vc), .pkt_dt(pkt_dt), .pkt_wc(pkt_wc), .pkt_dummy(pkt_dummy),
    .pld_data(pld_data), .pld_valid(pld_valid), .pld_ready(pld_ready),
    .lane_data(lane_data), .lane_write(lane_write), .lane_eof(lane_eof),
    .lane_hs(lane_hs), .lane_dummy(lane_dummy), .lane_request(lane_request),
    .busy(busy), .underflow(underflow), .dbg_state(dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;

  // expected lane bytes: {dummy, eof, data}
  logic [9:0] exp_q[$];

  typedef struct {
    logic             lng;
    logic             dmy;
    logic [1:0]       vc;
    logic [5:0]       dt;
    logic [15:0]      wc;
    int               n_pld;
    logic [15:0][7:0] pld;
    logic             tog;   // lane_request alternates 1/0
    int               n_exp;
    logic [23:0][7:0] exp;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference reflected CRC-16, bit-serial
  function automatic logic [15:0] crc_ref(input logic [15:0][7:0] d, input int n);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++)
      for (int b = 0; b < 8; b++)
        if (c[0] ^ d[i][b]) c = (c >> 1) ^ 16'h8408;
        else                c = c >> 1;
    return c;
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk_base) begin
    if (reset_n) begin
      if (lane_write) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL lane_byte: unexpected write data=%h eof=%b dummy=%b", lane_data, lane_eof, lane_dummy);
        end else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          if ({lane_dummy, lane_eof, lane_data} !== e) begin
            n_err++;
            $display("FAIL lane_byte: got {dummy,eof,data}=%b,%b,%h expected %b,%b,%h",
                     lane_dummy, lane_eof, lane_data, e[9], e[8], e[7:0]);
          end
        end
        n_vec++;
        if (!lane_request || lane_hs !== 1'b1) begin
          n_err++;
          $display("FAIL write_qual: lane_request=%b lane_hs=%b expected 1,1", lane_request, lane_hs);
        end
      end else if (lane_eof || lane_dummy) begin
        n_vec++;
        n_err++;
        $display("FAIL idle_flags: eof=%b dummy=%b expected 0,0 without write", lane_eof, lane_dummy);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic push_exp(input vec_t v);
    for (int i = 0; i < v.n_exp; i++)
      exp_q.push_back({v.dmy, (i == v.n_exp - 1), v.exp[i]});
  endtask

  task automatic accept(input vec_t v);
    pkt_valid = 1'b1; pkt_long = v.lng; pkt_dummy = v.dmy;
    pkt_vc = v.vc; pkt_dt = v.dt; pkt_wc = v.wc;
    @(negedge clk_base);
    chk("accept_ready", pkt_ready, 1);
    @(posedge clk_base); #1;
    pkt_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int starve_at, output int busy_cyc, output int uf_cnt);
    int pidx, cyc, starve_left;
    bit done, starved;
    push_exp(v);
    accept(v);
    pidx = 0; cyc = 0; done = 0; starved = 0; starve_left = 0;
    busy_cyc = 0; uf_cnt = 0;
    while (!done && cyc < 200) begin
      lane_request = v.tog ? (cyc % 2 == 0) : 1'b1;
      if (starve_at >= 0 && pidx == starve_at && !starved) begin
        starved = 1; starve_left = 3;
      end
      pld_valid = (pidx < v.n_pld) && (starve_left == 0);
      pld_data  = (pidx < v.n_pld) ? v.pld[pidx] : 8'h00;
      @(negedge clk_base);
      if (busy) busy_cyc++;
      if (underflow) uf_cnt++;
      if (pld_ready && pld_valid) pidx++;
      if (lane_write && lane_eof) done = 1;
      if (starve_left > 0 && lane_request) starve_left--;
      @(posedge clk_base); #1;
      cyc++;
    end
    lane_request = 1'b0; pld_valid = 1'b0;
    chk("eof_seen", done, 1);
    chk("sb_drained", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk_base);
    chk("back_idle_ready", pkt_ready, 1);
    chk("back_idle_busy", busy, 0);
    @(posedge clk_base); #1;
  endtask

  // ---------------- test ----------------
  initial begin
    int bc, uf, pidx;
    vec_t v;

    for (int i = 0; i < 6; i++) begin
      vecs[i].lng = 0; vecs[i].dmy = 0; vecs[i].vc = 0; vecs[i].dt = 0; vecs[i].wc = 0;
      vecs[i].n_pld = 0; vecs[i].pld = '0; vecs[i].tog = 0; vecs[i].n_exp = 0; vecs[i].exp = '0;
    end
    // short, all-zero data
    vecs[0].dt = 6'h01; vecs[0].n_exp = 4;
    vecs[0].exp[0] = 8'h01; vecs[0].exp[1] = 8'h00; vecs[0].exp[2] = 8'h00; vecs[0].exp[3] = 8'h07;
    // long, empty payload
    vecs[1].lng = 1; vecs[1].dt = 6'h29; vecs[1].n_exp = 6;
    vecs[1].exp[0] = 8'h29; vecs[1].exp[1] = 8'h00; vecs[1].exp[2] = 8'h00; vecs[1].exp[3] = 8'h1C;
    vecs[1].exp[4] = 8'hFF; vecs[1].exp[5] = 8'hFF;
    // long, "123456789" (checksum 0x6F91), toggling request
    vecs[2].lng = 1; vecs[2].dt = 6'h39; vecs[2].wc = 16'd9; vecs[2].n_pld = 9; vecs[2].tog = 1;
    vecs[2].n_exp = 15;
    vecs[2].exp[0] = 8'h39; vecs[2].exp[1] = 8'h09; vecs[2].exp[2] = 8'h00; vecs[2].exp[3] = 8'h30;
    for (int i = 0; i < 9; i++) begin
      vecs[2].pld[i]     = 8'(8'h31 + i);
      vecs[2].exp[4 + i] = 8'(8'h31 + i);
    end
    vecs[2].exp[13] = 8'h91; vecs[2].exp[14] = 8'h6F;
    // short, vc=1 with data
    vecs[3].vc = 2'd1; vecs[3].dt = 6'h05; vecs[3].wc = 16'h1234; vecs[3].n_exp = 4;
    vecs[3].exp[0] = 8'h45; vecs[3].exp[1] = 8'h34; vecs[3].exp[2] = 8'h12; vecs[3].exp[3] = 8'h1D;
    // dummy frame
    vecs[4].dmy = 1; vecs[4].n_exp = 1; vecs[4].exp[0] = 8'h00;
    // long, 4 bytes, vc=2, toggling request
    vecs[5].lng = 1; vecs[5].vc = 2'd2; vecs[5].dt = 6'h29; vecs[5].wc = 16'd4; vecs[5].n_pld = 4;
    vecs[5].tog = 1; vecs[5].n_exp = 10;
    vecs[5].pld[0] = 8'hDE; vecs[5].pld[1] = 8'hAD; vecs[5].pld[2] = 8'hBE; vecs[5].pld[3] = 8'hEF;
    vecs[5].exp[0] = 8'hA9; vecs[5].exp[1] = 8'h04; vecs[5].exp[2] = 8'h00; vecs[5].exp[3] = 8'h26;
    for (int i = 0; i < 4; i++) vecs[5].exp[4 + i] = vecs[5].pld[i];
    vecs[5].exp[8] = crc_ref(vecs[5].pld, 4) & 16'h00FF;
    vecs[5].exp[9] = crc_ref(vecs[5].pld, 4) >> 8;

    // reset values
    repeat (3) @(posedge clk_base);
    #1;
    reset_n = 1'b1; lane_request = 1'b1; pld_valid = 1'b1;
    @(negedge clk_base);
    chk("rst_pkt_ready", pkt_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_lane_write", lane_write, 0);
    chk("rst_pld_ready", pld_ready, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_state", dbg_state, ST_IDLE);
    @(posedge clk_base); #1;
    lane_request = 1'b0; pld_valid = 1'b0;

    // table
    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], -1, bc, uf);
      chk($sformatf("v%0d_underflow", i), uf, 0);
      if (!vecs[i].tog) chk($sformatf("v%0d_busy_cycles", i), bc, vecs[i].n_exp);
    end

    // payload starvation for 3 requested cycles after two bytes
    v = vecs[5]; v.tog = 0;
    run_vec(v, 2, bc, uf);
    chk("starve_underflow_pulses", uf, 3);
    chk("starve_busy_cycles", bc, 13);

    // dummy with pkt_valid held while busy
    exp_q.push_back({1'b1, 1'b1, 8'h00});
    accept(vecs[4]);
    pkt_valid = 1'b1; pkt_dummy = 1'b0; pkt_long = 1'b0; pkt_dt = 6'h01;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_base);
      chk("dummy_busy_ready", pkt_ready, 0);
      chk("dummy_busy_state", dbg_state, ST_DUMMY);
      @(posedge clk_base); #1;
    end
    pkt_valid = 1'b0; lane_request = 1'b1;
    @(negedge clk_base);
    chk("dummy_write", lane_write, 1);
    @(posedge clk_base); #1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_base);
      chk("dummy_not_queued", busy, 0);
      @(posedge clk_base); #1;
    end
    lane_request = 1'b0;
    chk("dummy_sb_drained", exp_q.size(), 0);
    exp_q.delete();

    // reset during payload
    v = vecs[5]; v.tog = 0;
    push_exp(v);
    accept(v);
    pidx = 0;
    for (int c = 0; c < 50 && pidx < 2; c++) begin
      lane_request = 1'b1; pld_valid = 1'b1; pld_data = v.pld[pidx];
      @(negedge clk_base);
      if (pld_ready && pld_valid) pidx++;
      @(posedge clk_base); #1;
    end
    chk("rstmid_in_payload", dbg_state, ST_PAYLOAD);
    chk("rstmid_bytes_left", exp_q.size(), 4);
    reset_n = 1'b0; lane_request = 1'b0; pld_valid = 1'b0;
    @(posedge clk_base); #1;
    reset_n = 1'b1; lane_request = 1'b1; pld_valid = 1'b1;
    @(negedge clk_base);
    chk("rstmid_pkt_ready", pkt_ready, 1);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_lane_write", lane_write, 0);
    chk("rstmid_eof", lane_eof, 0);
    chk("rstmid_pld_ready", pld_ready, 0);
    chk("rstmid_underflow", underflow, 0);
    exp_q.delete();
    @(posedge clk_base); #1;
    lane_request = 1'b0; pld_valid = 1'b0;
    run_vec(vecs[3], -1, bc, uf);
    chk("after_rst_busy_cycles", bc, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dsi_packet_assembler.md
DSI_PACKET_ASSEMBLER -- requirements
Module: dsi_packet_assembler

Interface
REQ-001 Parameter CRC_EN, default 1, meaning: 1 = compute the long-packet checksum; 0 = send checksum 0x0000.
REQ-002 Parameter HS_MODE, default 1, meaning: constant value driven on lane_hs.
REQ-003 clk_base  in  1  logic clock; all logic runs on its rising edge.
REQ-004 reset_n  in  1  reset, synchronous, active-low.
REQ-005 pkt_valid in 1, pkt_ready out 1: packet-request handshake.
REQ-006 pkt_long  in  1  0 = short packet, 1 = long packet.
REQ-007 pkt_vc in 2 (virtual channel); pkt_dt in 6 (data type).
REQ-008 pkt_wc  in  16  word count for long packets; {data1, data0} for short packets.
REQ-009 pkt_dummy  in  1  request a one-byte dummy frame (overrides pkt_long).
REQ-010 pld_data in 8, pld_valid in 1, pld_ready out 1: payload byte stream.
REQ-011 lane_data out 8, lane_write out 1, lane_eof out 1, lane_hs out 1, lane_dummy out 1, lane_request in 1: connect to the lane's data_input, data_write, end_of_frame, data_type, dummy_frame and data_request.
REQ-012 busy out 1; underflow out 1 (one-cycle pulse).

Function
REQ-013 States: IDLE, DI, WC0, WC1, ECC, PAYLOAD, CRC0, CRC1, DUMMY.
REQ-014 pkt_ready SHALL be 1 only in IDLE; a request is accepted on pkt_valid&&pkt_ready, and fields are registered that cycle.
REQ-015 IDLE transitions on accept: to DUMMY if pkt_dummy, else to DI.
REQ-016 The first lane byte SHALL appear on the cycle after accept (latency 1).
REQ-017 lane_write SHALL be 1 only when lane_request=1 in the same cycle; each such cycle transfers exactly one byte; a state advances only on a transfer.
REQ-018 Byte order: DI={vc,dt}; WC LSB; WC MSB; ECC={2'b00,P[5:0]}.
REQ-019 ECC SHALL be the DSI 6-bit Hamming code over D[23:0]={WC MSB, WC LSB, DI}.
REQ-020 Short packet: the ECC byte carries lane_eof=1; then IDLE.
REQ-021 Long packet: ECC goes to PAYLOAD.
REQ-022 PAYLOAD sends exactly WC bytes.
REQ-023 PAYLOAD with WC=0 is skipped, going straight to CRC0.
REQ-024 In PAYLOAD: pld_ready=lane_request; lane_write=lane_request&&pld_valid; lane_data=pld_data, passed through combinationally.
REQ-025 Payload starvation: in PAYLOAD with lane_request=1 and pld_valid=0, pulse underflow, hold no write, stay in PAYLOAD.
REQ-026 Payload counter is 16-bit; WC=0xFFFF sends 65535 bytes without wrap error.
REQ-027 Checksum: CRC-16, polynomial x^16+x^12+x^5+1, reflected (0x8408), seed 0xFFFF, LSB first, no final XOR, over payload bytes only; reseeded on every accept.
REQ-028 Checksum is sent CRC0=LSB, then CRC1=MSB; CRC1 carries lane_eof=1; then IDLE.
REQ-029 DUMMY sends one byte 0x00 with lane_dummy=1 and lane_eof=1; then IDLE.
REQ-030 lane_hs=HS_MODE on every written byte.
REQ-031 lane_eof and lane_dummy SHALL be 0 except on the bytes defined above.
REQ-032 busy=1 in every state except IDLE.
REQ-033 pkt_valid while busy is ignored and not queued.
REQ-034 pld_valid outside PAYLOAD is ignored (pld_ready=0).

Reset
REQ-035 With reset_n=0 at a clock edge: state=IDLE, counters=0, CRC=0xFFFF.
REQ-036 After reset, registered outputs SHALL read: pkt_ready=1, lane_write=0, lane_eof=0, lane_dummy=0, busy=0, underflow=0, pld_ready=0.
REQ-037 Reset mid-packet abandons the packet with no eof emitted; the first accept after reset starts cleanly.

Structure
REQ-038 A shared package dsi_pkg holds state encodings, DSI data-type constants and the CRC polynomial/seed.
REQ-039 A sub-module dsi_crc16 (byte-wide, combinational next-CRC) is natural; the ECC is a function in dsi_pkg.

Verification
REQ-040 Short: vc=0, dt=0x01, wc=0x0000, lane_request=1 -> bytes 01,00,00,07; eof on byte 4; busy for 4 cycles.
REQ-041 Long empty: vc=0, dt=0x29, wc=0 -> bytes 29,00,00,1C,FF,FF; eof on last byte only.
REQ-042 Long 4-byte payload, lane_request toggling 1/0 -> writes only on request cycles; CRC matches reference model; order preserved.
REQ-043 pld_valid low for 3 cycles mid-payload -> 3 underflow pulses, no writes, payload resumes intact.
REQ-044 Dummy request -> single byte 00 with lane_dummy=1, lane_eof=1; pkt_valid during busy not accepted.
REQ-045 reset_n low during PAYLOAD -> next cycle IDLE, outputs at reset values; a following short packet is correct.
